// File: rtl/mc_stage_ctrl.sv
// mc_stage_ctrl
// Multi-cycle IF/ID/EXE/MEM/WB control sequencer. It holds the architectural
// PC and runs req/ack handshakes with the instruction and data SRAMs. Either
// SRAM may insert any number of wait states.
//
// Optional feature macro: MC_BUS_TIMEOUT_EN
//   defined   : a wait-cycle counter, the ERR state and a sticky bus_err are
//               built.
//   undefined : IF and MEM wait forever for an ack, and bus_err is tied to 0.
//
// Ports
//   clk, resetn                 clock, asynchronous active-low reset
//   dec_gr_we/is_load/is_store  decoder class bits, stable from ID to retire
//   br_taken, br_target         redirect, sampled in the retire cycle
//   inst_req/inst_addr/inst_ack instruction SRAM handshake
//   ir_we                       instruction register load strobe
//   data_req/data_we/data_ack   data SRAM handshake (data_we marks a store)
//   rf_we                       register-file write strobe
//   pc                          architectural PC
//   state                       current state encoding
//   retire, debug_wb_pc         completion pulse and the PC that retired
//   bus_err                     sticky handshake timeout flag
module mc_stage_ctrl #(
    parameter int unsigned          ADDR_W    = 32,
    parameter logic [ADDR_W-1:0]    RESET_PC  = 32'h1c000000,
    parameter int unsigned          TO_CYCLES = 255,
    parameter int unsigned          CNT_W     = 8
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              dec_gr_we,
    input  logic              dec_is_load,
    input  logic              dec_is_store,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_target,
    output logic              inst_req,
    output logic [ADDR_W-1:0] inst_addr,
    input  logic              inst_ack,
    output logic              ir_we,
    output logic              data_req,
    output logic              data_we,
    input  logic              data_ack,
    output logic              rf_we,
    output logic [ADDR_W-1:0] pc,
    output logic [2:0]        state,
    output logic              retire,
    output logic [ADDR_W-1:0] debug_wb_pc,
    output logic              bus_err
);

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EXE = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4,
        S_ERR = 3'd5
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;

    logic inst_req_c, ir_we_c, data_req_c, data_we_c, rf_we_c, retire_c;
    // High in a wait cycle that exhausts the timeout budget.
    logic to_hit;
    // High on the cycle that moves the sequencer into ERR.
    logic err_go;

`ifdef MC_BUS_TIMEOUT_EN
    localparam logic [CNT_W:0] TO_LIM = (CNT_W+1)'(TO_CYCLES);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bus_err_q, bus_err_d;
    logic             waiting;

    // A wait cycle is a cycle in IF or MEM whose ack is still low. The count
    // that includes this cycle is cnt_q+1, so ERR is taken on the edge that
    // ends the TO_CYCLES-th wait cycle.
    always_comb begin
        waiting = ((state_q == S_IF) && !inst_ack) ||
                  ((state_q == S_MEM) && !data_ack);
        to_hit  = waiting && (({1'b0, cnt_q} + (CNT_W+1)'(1)) == TO_LIM);
        // Anything other than an ongoing wait clears the counter, so it
        // starts from zero on every entry to IF or MEM.
        cnt_d     = waiting ? (cnt_q + CNT_W'(1)) : '0;
        bus_err_d = bus_err_q | err_go;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q     <= '0;
            bus_err_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign bus_err = bus_err_q;
`else
    assign to_hit  = 1'b0;
    assign bus_err = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        inst_req_c = 1'b0;
        ir_we_c    = 1'b0;
        data_req_c = 1'b0;
        data_we_c  = 1'b0;
        rf_we_c    = 1'b0;
        retire_c   = 1'b0;
        err_go     = 1'b0;

        case (state_q)
            S_IF: begin
                inst_req_c = 1'b1;
                if (inst_ack) begin
                    ir_we_c = 1'b1;
                    state_d = S_ID;
                end else if (to_hit) begin
                    err_go  = 1'b1;
                    state_d = S_ERR;
                end
            end
            S_ID: state_d = S_EXE;
            S_EXE: begin
                if (dec_is_load || dec_is_store) begin
                    state_d = S_MEM;
                end else if (dec_gr_we) begin
                    state_d = S_WB;
                end else begin
                    // Branches finish here: no memory, no write-back.
                    retire_c = 1'b1;
                    state_d  = S_IF;
                end
            end
            S_MEM: begin
                data_req_c = 1'b1;
                data_we_c  = dec_is_store;
                if (data_ack) begin
                    if (dec_is_store) begin
                        retire_c = 1'b1;
                        state_d  = S_IF;
                    end else begin
                        state_d  = S_WB;
                    end
                end else if (to_hit) begin
                    err_go  = 1'b1;
                    state_d = S_ERR;
                end
            end
            S_WB: begin
                rf_we_c  = dec_gr_we;
                retire_c = 1'b1;
                state_d  = S_IF;
            end
            S_ERR: state_d = S_ERR;
            default: state_d = S_IF;
        endcase

        // The +4 wraps naturally at the ADDR_W boundary.
        if (retire_c) begin
            pc_d = br_taken ? br_target : (pc_q + ADDR_W'(4));
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IF;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // The state register already reads IF during reset, so the strobes are
    // masked by resetn to keep the SRAMs and register file quiet until release.
    assign inst_req    = inst_req_c & resetn;
    assign ir_we       = ir_we_c    & resetn;
    assign data_req    = data_req_c & resetn;
    assign data_we     = data_we_c  & resetn;
    assign rf_we       = rf_we_c    & resetn;
    assign retire      = retire_c   & resetn;
    assign debug_wb_pc = retire ? pc_q : '0;
    assign inst_addr   = pc_q;
    assign pc          = pc_q;
    assign state       = state_q;

endmodule

// File: tb/tb_mc_stage_ctrl.sv
module tb_mc_stage_ctrl;

    logic        clk;
    logic        resetn;
    logic        dec_gr_we, dec_is_load, dec_is_store;
    logic        br_taken;
    logic [31:0] br_target;
    logic        inst_req, inst_ack, ir_we;
    logic [31:0] inst_addr;
    logic        data_req, data_we, data_ack;
    logic        rf_we, retire, bus_err;
    logic [31:0] pc, debug_wb_pc;
    logic [2:0]  state;

    int nvec = 0;
    int nerr = 0;

    mc_stage_ctrl #(
        .ADDR_W(32), .RESET_PC(32'h1c000000), .TO_CYCLES(4), .CNT_W(8)
    ) dut (
        .clk(clk), .resetn(resetn),
        .dec_gr_we(dec_gr_we), .dec_is_load(dec_is_load), .dec_is_store(dec_is_store),
        .br_taken(br_taken), .br_target(br_target),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_ack(inst_ack),
        .ir_we(ir_we),
        .data_req(data_req), .data_we(data_we), .data_ack(data_ack),
        .rf_we(rf_we), .pc(pc), .state(state),
        .retire(retire), .debug_wb_pc(debug_wb_pc), .bus_err(bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, observed=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one instruction starting in its IF cycle. Memories answer after
    // iw / dw requested cycles. exp_cyc is the 1-based cycle holding retire.
    task automatic exec(input string tag, input logic gr, input logic ld,
                        input logic st, input logic bt, input logic [31:0] tgt,
                        input int iw, input int dw, input int exp_cyc,
                        input int exp_rf, input logic [31:0] exp_pc,
                        input logic [31:0] exp_next);
        int n, ic, dc, rfc, irc, both;
        logic done;
        dec_gr_we = gr; dec_is_load = ld; dec_is_store = st;
        br_taken = bt; br_target = tgt;
        n = 0; ic = 0; dc = 0; rfc = 0; irc = 0; both = 0; done = 1'b0;
        while (!done && n < 40) begin
            n++;
            inst_ack = (ic >= iw);
            data_ack = (dc >= dw);
            #1;
            if (inst_req) ic++;
            if (data_req) dc++;
            if (rf_we) rfc++;
            if (ir_we) irc++;
            if (inst_req && data_req) both++;
            if (retire) begin
                done = 1'b1;
                chk({tag, "_wbpc"}, debug_wb_pc, exp_pc);
            end
            tick();
        end
        chk({tag, "_cycles"}, n, exp_cyc);
        chk({tag, "_rfwe_cnt"}, rfc, exp_rf);
        chk({tag, "_irwe_cnt"}, irc, 1);
        chk({tag, "_req_overlap"}, both, 0);
        chk({tag, "_next_addr"}, inst_addr, exp_next);
        chk({tag, "_next_state"}, {29'd0, state}, 32'd0);
    endtask

    initial begin
        resetn = 1'b0;
        dec_gr_we = 0; dec_is_load = 0; dec_is_store = 0;
        br_taken = 0; br_target = 32'h0;
        inst_ack = 1'b1; data_ack = 1'b0;
        repeat (3) tick();

        // Held in reset
        chk("rst_state", {29'd0, state}, 32'd0);
        chk("rst_pc", pc, 32'h1c000000);
        chk("rst_inst_req", {31'd0, inst_req}, 32'd0);
        chk("rst_retire", {31'd0, retire}, 32'd0);
        chk("rst_bus_err", {31'd0, bus_err}, 32'd0);

        // First cycle after release
        resetn = 1'b1;
        #1;
        chk("rel_inst_req", {31'd0, inst_req}, 32'd1);
        chk("rel_inst_addr", inst_addr, 32'h1c000000);
        chk("rel_wbpc_idle", debug_wb_pc, 32'h0);

        // Zero-wait mix
        exec("add",  1, 0, 0, 0, 32'h0, 0, 0, 4, 1, 32'h1c000000, 32'h1c000004);
        exec("ldw",  1, 1, 0, 0, 32'h0, 0, 0, 5, 1, 32'h1c000004, 32'h1c000008);
        exec("stw",  0, 0, 1, 0, 32'h0, 0, 0, 4, 0, 32'h1c000008, 32'h1c00000c);
        exec("beqn", 0, 0, 0, 0, 32'h0, 0, 0, 3, 0, 32'h1c00000c, 32'h1c000010);

        // Wait states: 3 on fetch, 2 on data
        exec("ldw_wait", 1, 1, 0, 0, 32'h0, 3, 2, 10, 1, 32'h1c000010, 32'h1c000014);

        // Taken branches and PC wrap
        exec("beqt", 0, 0, 0, 1, 32'h1c000100, 0, 0, 3, 0, 32'h1c000014, 32'h1c000100);
        exec("jmp_top", 0, 0, 0, 1, 32'hfffffffc, 0, 0, 3, 0, 32'h1c000100, 32'hfffffffc);
        exec("wrap", 1, 0, 0, 0, 32'h0, 0, 0, 4, 1, 32'hfffffffc, 32'h00000000);

        // Reset in the middle of a load's MEM wait
        dec_gr_we = 1; dec_is_load = 1; dec_is_store = 0; br_taken = 0;
        inst_ack = 1'b1; data_ack = 1'b0;
        tick(); tick(); tick();
        chk("mid_mem_state", {29'd0, state}, 32'd3);
        chk("mid_mem_dreq", {31'd0, data_req}, 32'd1);
        resetn = 1'b0;
        #1;
        chk("mid_rst_dreq", {31'd0, data_req}, 32'd0);
        tick();
        chk("mid_rst_state", {29'd0, state}, 32'd0);
        chk("mid_rst_pc", pc, 32'h1c000000);
        resetn = 1'b1;
        #1;

`ifdef MC_BUS_TIMEOUT_EN
        // data_ack stuck low with a 4-cycle budget
        dec_gr_we = 1; dec_is_load = 1; dec_is_store = 0;
        inst_ack = 1'b1; data_ack = 1'b0;
        tick(); tick(); tick();
        chk("to_wait1_state", {29'd0, state}, 32'd3);
        tick(); tick(); tick();
        chk("to_wait4_state", {29'd0, state}, 32'd3);
        chk("to_wait4_err", {31'd0, bus_err}, 32'd0);
        tick();
        chk("to_err_state", {29'd0, state}, 32'd5);
        chk("to_err_flag", {31'd0, bus_err}, 32'd1);
        begin
            int act = 0;
            inst_ack = 1'b1; data_ack = 1'b1;
            for (int i = 0; i < 6; i++) begin
                #1;
                if (inst_req || data_req || ir_we || rf_we || retire || data_we || (state != 3'd5))
                    act++;
                tick();
            end
            chk("to_err_quiet", act, 0);
        end
        resetn = 1'b0;
        #1;
        chk("to_rst_flag", {31'd0, bus_err}, 32'd0);
        chk("to_rst_state", {29'd0, state}, 32'd0);
        tick();
        resetn = 1'b1;
        #1;
`else
        // Long fetch stall with no timeout hardware
        begin
            int bad = 0;
            dec_gr_we = 1; dec_is_load = 0; dec_is_store = 0;
            for (int i = 0; i < 1000; i++) begin
                inst_ack = 1'b0;
                #1;
                if (bus_err || (state != 3'd0) || !inst_req || ir_we) bad++;
                tick();
            end
            chk("stall_no_err", bad, 0);
            chk("stall_pc", pc, 32'h1c000000);
        end
`endif
        exec("post_add", 1, 0, 0, 0, 32'h0, 0, 0, 4, 1, 32'h1c000000, 32'h1c000004);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/mc_stage_ctrl.md
# mc_stage_ctrl

Parametrised multi-cycle control sequencer for the LoongArch teaching core. It steps each instruction through IF/ID/EXE/MEM/WB, holds the architectural PC, and issues request/acknowledge handshakes to the instruction and data SRAMs so that memory may insert any number of wait states. It sits between the decoder/branch unit and the datapath, and supplies the register-file write enable and the retire/debug strobes.

## Interface
- `ADDR_W`, 32, PC and address width.
- `RESET_PC`, 32'h1c000000, first fetch address after reset.
- `TO_CYCLES`, 255, maximum wait cycles for an ack before a bus error; 1..2^`CNT_W`-1.
- `CNT_W`, 8, timeout counter width.

Ports:
- `clk` in 1: the single clock.
- `resetn` in 1: reset, asynchronous and active-low.
- `dec_gr_we` in 1: the instruction writes the register file.
- `dec_is_load` in 1: the instruction is ld.w.
- `dec_is_store` in 1: the instruction is st.w.
- `br_taken` in 1: redirect. Sampled when the instruction retires.
- `br_target` in `ADDR_W`: redirect target.
- `inst_req` out 1: instruction fetch request.
- `inst_addr` out `ADDR_W`: fetch address, equal to `pc`.
- `inst_ack` in 1: fetch data valid this cycle.
- `ir_we` out 1: datapath latches the instruction.
- `data_req` out 1: data SRAM request.
- `data_we` out 1: store qualifier for `data_req`.
- `data_ack` in 1: data access complete; load data valid this cycle.
- `rf_we` out 1: register-file write strobe.
- `pc` out `ADDR_W`: architectural PC (register).
- `state` out 3: current state encoding.
- `retire` out 1: one-cycle pulse marking instruction completion.
- `debug_wb_pc` out `ADDR_W`: PC of the retiring instruction.
- `bus_err` out 1: sticky timeout flag.

## Operation
- State encodings: IF=0, ID=1, EXE=2, MEM=3, WB=4, ERR=5. All other encodings go to IF.
- **IF**
  - `inst_req`=1.
  - On `inst_ack`: pulse `ir_we` and go to ID.
  - Otherwise hold in IF.
- **ID:** go to EXE unconditionally.
- **EXE**
  - `dec_is_load` or `dec_is_store` → MEM.
  - Else `dec_gr_we` → WB.
  - Else (b/beq/bne): retire and go to IF.
- **MEM**
  - `data_req`=1 and `data_we`=`dec_is_store`.
  - On `data_ack`: a store retires and goes to IF; a load goes to WB.
  - Otherwise hold in MEM.
- **WB:** `rf_we`=`dec_gr_we`, retire, go to IF.
- **Retire cycle**
  - `retire`=1 and `debug_wb_pc`=`pc`.
  - `pc` ← `br_taken` ? `br_target` : `pc`+4.
  - The +4 wraps modulo 2^`ADDR_W`.
- **Decoder inputs:** must be stable from ID until retire. The block does not latch them.
- **Handshake rules**
  - A request stays asserted until its ack is seen.
  - An ack in the same cycle as the request is legal (zero wait).
  - Acks outside the matching state are ignored.
  - `data_req` and `inst_req` are never high together.
- **Timeout counter**
  - Clears on entry to IF or MEM.
  - Increments each cycle the ack is low.
  - When the count reaches `TO_CYCLES` with no ack: go to ERR, set `bus_err`=1.
  - ERR drives every request and enable low and is left only by reset.
- **Reset**
  - Applies at any time, including mid-transaction; the open transaction is abandoned.
  - While reset is asserted: state=IF, `pc`=`RESET_PC`, `bus_err`=0, counter=0.
  - `inst_req`, `ir_we`, `data_req`, `data_we`, `rf_we`, `retire` are gated to 0 while `resetn`=0.
  - `debug_wb_pc` reads 0 whenever `retire`=0.

## Timing
- Control outputs are Moore decodes of `state`, except:
  - `ir_we` is qualified by `inst_ack`.
  - `retire` is qualified by `data_ack` in MEM.
- The first `inst_req` appears in the first cycle with `resetn`=1.
- Cycles per instruction with zero-wait memory:
  - Branch: 3.
  - ALU / jirl / bl: 4 (IF ID EXE WB).
  - Store: 4 (IF ID EXE MEM).
  - Load: 5.
- Each wait cycle on a handshake adds one cycle to the instruction.
- `pc` updates on the clock edge ending the retire cycle, so the next `inst_addr` is valid in the following IF cycle.
- ERR is entered on the edge after the cycle in which the count equals `TO_CYCLES`.

## Configuration
- Macro: `MC_BUS_TIMEOUT_EN`.
- **Defined:** the timeout counter, the ERR state and `bus_err` are built as described above.
- **Undefined:**
  - No counter is built and ERR is unreachable.
  - IF and MEM wait indefinitely for an ack.
  - `bus_err` is tied to 0.
  - `TO_CYCLES` and `CNT_W` are unused.

## Test plan
- **Reset:** release `resetn` with `inst_ack` tied to 1.
  - First cycle: `inst_req`=1 and `inst_addr`=0x1c000000.
  - Assert `resetn`=0 mid-MEM: next cycle state=IF and `pc`=0x1c000000.
- **Zero-wait mix:** run add, ld.w, st.w, beq(not taken).
  - `retire` pulses after 4, 5, 4, 3 cycles.
  - `debug_wb_pc` reads 0x1c000000, 0x1c000004, 0x1c000008, 0x1c00000c.
- **Wait states:** hold `inst_ack` low 3 cycles and `data_ack` low 2 cycles on a ld.w.
  - Retire comes 10 cycles after the fetch start.
  - `rf_we` is high exactly 1 cycle.
- **Branch and wrap:**
  - `br_taken`=1 with `br_target`=0x1c000100 at retire → next `inst_addr`=0x1c000100.
  - `pc`=0xfffffffc with not-taken → next `pc`=0x00000000.
- **Timeout (macro defined):** `TO_CYCLES`=4 and `data_ack` stuck low.
  - State=ERR and `bus_err`=1 after 4 wait cycles.
  - All requests stay low until reset.
- **No timeout (macro undefined):** stall `inst_ack` 1000 cycles.
  - `bus_err` stays 0.
  - The first ack completes the fetch normally.
